sysid_info_regs: RTL and testbench
==================================

Name: sysid_info_regs

Overview:
Parametrised system-identification and housekeeping slave on the Avalon-MM bus. It returns the build ID and timestamp, and adds the following:
- a 64-bit free-running uptime counter with an atomic read
- a seconds counter and heartbeat output
- a byte-writable scratch register
- a capability word

Read latency is 1 cycle, registered. The Nios II software uses the block for build checks, timing and bus sanity tests.

Parameters:
SYSID_ID, 32'h0000_0000, system ID returned at address 0
SYSID_TIMESTAMP, 32'd1353410341, generation timestamp returned at address 1
CLK_FREQ_HZ, 50000000, clock frequency; sets the seconds prescaler terminal count (must be >= 2)
VERSION, 16'd2, block version reported in the capability word

Ports:
clock  in  1  system clock; all logic is on the rising edge
reset_n  in  1  asynchronous, active-low reset
address  in  3  word address
read  in  1  read strobe, single cycle
write  in  1  write strobe, single cycle
writedata  in  32  write data
byteenable  in  4  byte lanes for writes
readdata  out  32  registered read data
readdatavalid  out  1  high for 1 cycle, the cycle after an accepted read
heartbeat  out  1  toggles once per elapsed second

Behaviour:
- Reset (reset_n low, asynchronous): all of the following clear to 0:
  - outputs: readdata, readdatavalid, heartbeat
  - internal state: uptime counter, uptime-high snapshot, prescaler, seconds, scratch
  - Reset mid-read suppresses any pending readdatavalid.
- Address map (reads):
  - 0: SYSID_ID
  - 1: SYSID_TIMESTAMP
  - 2: UPTIME_LO
  - 3: UPTIME_HI snapshot
  - 4: SCRATCH
  - 5: SECONDS
  - 6: CAP = {VERSION[15:0], CLK_FREQ_HZ/1000000 truncated to 16 bits}
  - 7: reserved, reads 0
- Read timing: read in cycle N → readdata and readdatavalid=1 in cycle N+1.
  - readdata holds its value until the next read.
  - readdatavalid=0 in all other cycles.
- Uptime:
  - 64-bit counter, +1 every clock; wraps from 2^64-1 to 0.
  - A read of address 2 returns the low 32 bits as sampled in the read cycle.
  - In the same edge, bits [63:32] of that sample are latched into the snapshot.
  - A read of address 3 returns the snapshot. It does not resample, so the LO-then-HI read pair is coherent across a carry.
- Prescaler and seconds:
  - Prescaler counts 0..CLK_FREQ_HZ-1.
  - At the terminal count the prescaler returns to 0, SECONDS increments (32-bit, wraps) and heartbeat toggles.
- Writes:
  - Address 4: each byte lane i with byteenable[i]=1 updates SCRATCH[8i+7:8i].
  - Address 2: clears the uptime counter to 0 (counter reads 0 the cycle after the write, then resumes counting). The snapshot is unchanged.
  - Address 5: clears SECONDS and the prescaler. heartbeat is unchanged.
  - Addresses 0, 1, 3, 6, 7: writes are ignored.
- Clear collisions:
  - A clear of uptime takes precedence over the increment in that cycle.
  - A clear of seconds takes precedence over a coincident terminal count. No heartbeat toggle occurs in that cycle.
- Simultaneous read and write (illegal on the bus): the read is serviced and the write is dropped.
- Throughput: back-to-back reads give one readdatavalid per read, with no bubbles.

Decomposition:
- Shared package sysid_pkg holds:
  - address constants ADDR_ID, ADDR_TS, ADDR_UP_LO, ADDR_UP_HI, ADDR_SCRATCH, ADDR_SECONDS, ADDR_CAP
  - DATA_W = 32 and UPTIME_W = 64
- One sub-module, sysid_seconds_timer: contains the prescaler, SECONDS, heartbeat and the synchronous clear input.

Test Plan:
- Reset, then read addresses 0, 1 and 6 (defaults) → readdata = 0x00000000, then 1353410341, then 0x00020032. readdatavalid is high exactly 1 cycle after each read.
- Write 0xAABBCCDD to address 4 with byteenable=4'b1111, then write 0x11223344 with byteenable=4'b0101; read address 4 → 0xAA22CC44.
- Force the uptime counter to 0x00000000_FFFFFFFF: read address 2 at that value, then read address 3 two cycles later → 0xFFFFFFFF then 0x00000000, not 1. Write address 2 → a read of address 2 in the following cycle returns 0.
- CLK_FREQ_HZ=10:
  - after 35 clocks from reset, SECONDS reads 3 and heartbeat=1;
  - write address 5 on the cycle the terminal count is reached → SECONDS=0, heartbeat not toggled.
- Read of address 7, and simultaneous read+write to address 4 → readdata=0 for address 7; SCRATCH unchanged by the dropped write.
- Assert reset_n low asynchronously between a read and its response cycle → readdatavalid stays 0, and all outputs are 0 while reset is held.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID / housekeeping slave: bus widths and the register address map.
package sysid_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned UPTIME_W = 64;

  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_TS      = 3'd1;
  localparam logic [2:0] ADDR_UP_LO   = 3'd2;
  localparam logic [2:0] ADDR_UP_HI   = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH = 3'd4;
  localparam logic [2:0] ADDR_SECONDS = 3'd5;
  localparam logic [2:0] ADDR_CAP     = 3'd6;

endpackage

// File: rtl/sysid_seconds_timer.sv
// Prescaled seconds counter with heartbeat toggle and a synchronous clear.
module sysid_seconds_timer
  import sysid_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  output logic [DATA_W-1:0] seconds,
  output logic              heartbeat
);

  localparam int unsigned     PRE_W  = $clog2(CLK_FREQ_HZ);
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_FREQ_HZ - 1);

  logic [PRE_W-1:0]  prescaler_q, prescaler_d;
  logic [DATA_W-1:0] seconds_q, seconds_d;
  logic              heartbeat_q, heartbeat_d;

  // Clear wins over a coincident terminal count, so no heartbeat toggle then.
  always_comb begin
    prescaler_d = prescaler_q + PRE_W'(1);
    seconds_d   = seconds_q;
    heartbeat_d = heartbeat_q;
    if (clear) begin
      prescaler_d = '0;
      seconds_d   = '0;
    end else if (prescaler_q == PRE_TC) begin
      prescaler_d = '0;
      seconds_d   = seconds_q + 32'd1;
      heartbeat_d = ~heartbeat_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler_q <= '0;
      seconds_q   <= '0;
      heartbeat_q <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      seconds_q   <= seconds_d;
      heartbeat_q <= heartbeat_d;
    end
  end

  assign seconds   = seconds_q;
  assign heartbeat = heartbeat_q;

endmodule

// File: rtl/sysid_info_regs.sv
// Avalon-MM system-ID and housekeeping slave: ID/timestamp, coherent 64-bit uptime, seconds,
// scratch and capability registers with a registered one-cycle read.
module sysid_info_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSID_ID        = 32'h0000_0000,
  parameter logic [31:0] SYSID_TIMESTAMP = 32'd1353410341,
  parameter int unsigned CLK_FREQ_HZ     = 50000000,
  parameter logic [15:0] VERSION         = 16'd2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [3:0]        byteenable,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              heartbeat
);

  localparam logic [15:0]       FREQ_MHZ = 16'(CLK_FREQ_HZ / 1000000);
  localparam logic [DATA_W-1:0] CAP_WORD = {VERSION, FREQ_MHZ};

  logic [UPTIME_W-1:0] uptime_q, uptime_d;
  logic [DATA_W-1:0]   snap_q, snap_d;
  logic [DATA_W-1:0]   scratch_q, scratch_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q;
  logic [DATA_W-1:0]   seconds;
  logic                wr_en;

  // A write coinciding with a read is dropped.
  assign wr_en = write & ~read;

  sysid_seconds_timer #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_seconds_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (wr_en && (address == ADDR_SECONDS)),
    .seconds  (seconds),
    .heartbeat(heartbeat)
  );

  always_comb begin
    uptime_d = uptime_q + 64'd1;
    if (wr_en && (address == ADDR_UP_LO)) uptime_d = '0;

    // Reading LO latches HI from the same sample so the pair stays coherent across a carry.
    snap_d = snap_q;
    if (read && (address == ADDR_UP_LO)) snap_d = uptime_q[UPTIME_W-1 -: DATA_W];

    scratch_d = scratch_q;
    if (wr_en && (address == ADDR_SCRATCH)) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) scratch_d[8*i +: 8] = writedata[8*i +: 8];
      end
    end

    rdata_d = rdata_q;
    if (read) begin
      case (address)
        ADDR_ID:      rdata_d = SYSID_ID;
        ADDR_TS:      rdata_d = SYSID_TIMESTAMP;
        ADDR_UP_LO:   rdata_d = uptime_q[DATA_W-1:0];
        ADDR_UP_HI:   rdata_d = snap_q;
        ADDR_SCRATCH: rdata_d = scratch_q;
        ADDR_SECONDS: rdata_d = seconds;
        ADDR_CAP:     rdata_d = CAP_WORD;
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q  <= '0;
      snap_q    <= '0;
      scratch_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      uptime_q  <= uptime_d;
      snap_q    <= snap_d;
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= read;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_info_regs.sv
// Self-checking bench: directed plan steps plus random bus traffic against a behavioural model,
// run on a default instance and a 10 Hz instance sharing one bus.
module tb_sysid_info_regs;
  import sysid_pkg::*;

  localparam longint unsigned FREQ_A = 50000000;
  localparam longint unsigned FREQ_B = 10;
  localparam logic [31:0]     TS     = 32'd1353410341;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata_a, readdata_b;
  logic        readdatavalid_a, readdatavalid_b;
  logic        heartbeat_a, heartbeat_b;

  sysid_info_regs dut_a (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata_a),
    .readdatavalid(readdatavalid_a),
    .heartbeat    (heartbeat_a)
  );

  sysid_info_regs #(
    .CLK_FREQ_HZ(10)
  ) dut_b (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata_b),
    .readdatavalid(readdatavalid_b),
    .heartbeat    (heartbeat_b)
  );

  always #5 clock = ~clock;

  // Model: uptime is clocks since reset/clear, seconds is clocks-since-clear / frequency.
  logic [63:0]     m_up;
  logic [31:0]     m_snap, m_scratch;
  longint unsigned t_clr;
  int unsigned     ticks_a, ticks_b;
  logic [31:0]     exp_rd_a, exp_rd_b;
  int              n_checks = 0;
  int              n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [2:0] a, input longint unsigned freq);
    case (a)
      3'd0:    return 32'h0;
      3'd1:    return TS;
      3'd2:    return m_up[31:0];
      3'd3:    return m_snap;
      3'd4:    return m_scratch;
      3'd5:    return 32'(t_clr / freq);
      3'd6:    return {16'd2, 16'(freq / 64'd1000000)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_zero();
    m_up = '0; m_snap = '0; m_scratch = '0; t_clr = 0;
    ticks_a = 0; ticks_b = 0; exp_rd_a = '0; exp_rd_b = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_a"}, readdata_a, 32'h0);
    check({tag, "_rd_b"}, readdata_b, 32'h0);
    check({tag, "_rv_a"}, {31'b0, readdatavalid_a}, 32'h0);
    check({tag, "_rv_b"}, {31'b0, readdatavalid_b}, 32'h0);
    check({tag, "_hb_a"}, {31'b0, heartbeat_a}, 32'h0);
    check({tag, "_hb_b"}, {31'b0, heartbeat_b}, 32'h0);
  endtask

  // Entered just after a rising edge; drives one bus cycle and checks the outputs after the edge.
  task automatic cycle(input logic rd, input logic wr, input logic [2:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    logic wr_ok;
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    wr_ok = wr && !rd;
    if (rd) begin
      exp_rd_a = model_rd(a, FREQ_A);
      exp_rd_b = model_rd(a, FREQ_B);
      if (a == ADDR_UP_LO) m_snap = m_up[63:32];
    end
    if (wr_ok && a == ADDR_SCRATCH) begin
      for (int i = 0; i < 4; i++) if (be[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
    end
    m_up = (wr_ok && a == ADDR_UP_LO) ? 64'd0 : m_up + 64'd1;
    if (wr_ok && a == ADDR_SECONDS) t_clr = 0;
    else begin
      t_clr++;
      if (t_clr % FREQ_A == 0) ticks_a++;
      if (t_clr % FREQ_B == 0) ticks_b++;
    end
    @(posedge clock);
    #1;
    read = 1'b0; write = 1'b0;
    check("rvalid_a", {31'b0, readdatavalid_a}, {31'b0, rd});
    check("rvalid_b", {31'b0, readdatavalid_b}, {31'b0, rd});
    check("rdata_a", readdata_a, exp_rd_a);
    check("rdata_b", readdata_b, exp_rd_b);
    check("hb_a", {31'b0, heartbeat_a}, {31'b0, ticks_a[0]});
    check("hb_b", {31'b0, heartbeat_b}, {31'b0, ticks_b[0]});
  endtask

  task automatic rd_cycle(input logic [2:0] a);
    cycle(1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic wr_cycle(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
    cycle(1'b0, 1'b1, a, wd, be);
  endtask

  task automatic apply_reset();
    read = 1'b0; write = 1'b0;
    reset_n = 1'b0;
    model_zero();
    #1;
    check_all_zero("rst_async");
    @(posedge clock);
    #1;
    check_all_zero("rst_held");
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clock);
    #1;
    apply_reset();

    rd_cycle(ADDR_ID);
    check("id", readdata_a, 32'h0000_0000);
    rd_cycle(ADDR_TS);
    check("ts", readdata_a, 32'd1353410341);
    rd_cycle(ADDR_CAP);
    check("cap", readdata_a, 32'h0002_0032);
    cycle(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);

    wr_cycle(ADDR_SCRATCH, 32'hAABB_CCDD, 4'b1111);
    wr_cycle(ADDR_SCRATCH, 32'h1122_3344, 4'b0101);
    rd_cycle(ADDR_SCRATCH);
    check("scratch_be", readdata_a, 32'hAA22_CC44);

    force dut_a.uptime_q = 64'h0000_0000_FFFF_FFFF;
    force dut_b.uptime_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut_a.uptime_q;
    release dut_b.uptime_q;
    m_up = 64'h0000_0000_FFFF_FFFF;
    rd_cycle(ADDR_UP_LO);
    check("up_lo_carry", readdata_a, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    rd_cycle(ADDR_UP_HI);
    check("up_hi_snap", readdata_a, 32'h0000_0000);
    wr_cycle(ADDR_UP_LO, 32'h1234_5678, 4'hF);
    rd_cycle(ADDR_UP_LO);
    check("up_clear", readdata_a, 32'h0000_0000);

    rd_cycle(3'd7);
    check("rsvd", readdata_a, 32'h0);
    cycle(1'b1, 1'b1, ADDR_SCRATCH, 32'h5555_5555, 4'hF);
    rd_cycle(ADDR_SCRATCH);
    check("rw_drop", readdata_a, 32'hAA22_CC44);

    apply_reset();
    for (int i = 0; i < 35; i++) cycle(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    rd_cycle(ADDR_SECONDS);
    check("sec_35", readdata_b, 32'd3);
    check("hb_35", {31'b0, heartbeat_b}, 32'd1);
    wr_cycle(ADDR_SECONDS, 32'h0, 4'hF);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    wr_cycle(ADDR_SECONDS, 32'h0, 4'hF);
    rd_cycle(ADDR_SECONDS);
    check("sec_clr_tc", readdata_b, 32'd0);
    check("hb_clr_tc", {31'b0, heartbeat_b}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      int unsigned op;
      op = $urandom_range(0, 7);
      cycle((op < 3) || (op == 7), (op >= 3), 3'($urandom_range(0, 7)), $urandom,
            4'($urandom_range(0, 15)));
    end

    rd_cycle(ADDR_TS);
    read = 1'b1; address = ADDR_ID;
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("midrd_async");
    @(posedge clock);
    #1;
    check_all_zero("midrd_edge");
    read = 1'b0;
    apply_reset();
    rd_cycle(ADDR_CAP);
    check("cap_b", readdata_b, 32'h0002_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
